axil_master_engine: RTL and testbench
=====================================

# axil_master_engine

Single-outstanding AXI4-Lite master that turns simple command/response handshakes from local logic into AXI4-Lite read and write transactions. Sits between control logic (sequencers, self-test, version readers) and an AXI4-Lite interconnect or slave register block. Issues one transaction at a time, returns read data and response code, and can optionally flag slaves that stall.

## Interface
- AXI_DATA_WIDTH, 32: data bus width; WSTRB width is AXI_DATA_WIDTH/8.
- AXI_ADDR_WIDTH, 32: address width.
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with AXIL_MASTER_TIMEOUT_EN.
- AXI_ACLK  in  1  sole clock; all logic on rising edge.
- AXI_ARESET  in  1  reset, synchronous, active-high.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine accepts a command; high only in IDLE.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  AXI_ADDR_WIDTH  byte address.
- CMD_WDATA  in  AXI_DATA_WIDTH  write data, ignored for reads.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer takes response.
- RSP_DATA  out  AXI_DATA_WIDTH  read data; 0 after writes.
- RSP_RESP  out  2  captured BRESP/RRESP.
- TIMEOUT  out  1  sticky watchdog flag; 0 without the macro.
- M_AXI_AW{ADDR,VALID,READY,PROT}, M_AXI_W{DATA,STRB,VALID,READY}, M_AXI_B{RESP,VALID,READY}, M_AXI_AR{ADDR,VALID,READY,PROT}, M_AXI_R{DATA,RESP,VALID,READY}: standard AXI4-Lite master channels. PROT is driven 3'b000. WSTRB is driven all-ones.

## Operation
- States are IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESPOND.
- IDLE: CMD_READY=1. On CMD_VALID, register the address and data. If CMD_WRITE, go to WR_ADDR_DATA; otherwise go to RD_ADDR.
- WR_ADDR_DATA:
  - AWVALID and WVALID are both high on entry.
  - Each drops independently on its own handshake. The two handshakes may occur in either order or in the same cycle.
  - Move to WR_RESP in the cycle after both have completed.
- WR_RESP: BREADY=1. On the B handshake, capture BRESP, set RSP_DATA=0, go to RESPOND.
- RD_ADDR: ARVALID=1 until the AR handshake, then go to RD_DATA.
- RD_DATA: RREADY=1. On the R handshake, capture RDATA/RRESP, go to RESPOND.
- RESPOND: RSP_VALID=1. On RSP_READY, go to IDLE.
- Once asserted, a VALID never deasserts before its handshake. ADDR and DATA are stable while VALID is high.
- A RESP of SLVERR or DECERR is passed through unchanged. The engine does not retry.
- Reset mid-transaction: at the next edge all VALID/READY outputs go 0 and the state goes to IDLE. The attached slave must share the reset.

## Timing
- Reset values: CMD_READY=1; RSP_VALID=0; RSP_DATA=0; RSP_RESP=0; TIMEOUT=0; all M_AXI VALID/READY=0; AXI addresses and data=0.
- Cycle 0 is command acceptance. AW/W/AR VALID rise at cycle 1 (registered).
- Best-case write: AW and W handshakes at cycle 1, B handshake at cycle 2, RSP_VALID at cycle 3.
- Best-case read: AR handshake at cycle 1, R handshake at cycle 2, RSP_VALID at cycle 3.
- RSP_VALID and RSP_READY both high at cycle n puts CMD_READY=1 at cycle n+1. Throughput is at most one transaction per 4 cycles.
- BREADY and RREADY are asserted only in their response states. A slave holding BVALID/RVALID earlier is legal and is accepted on state entry.

## Configuration
- AXIL_MASTER_TIMEOUT_EN defined:
  - A counter clears on entry to every non-IDLE, non-RESPOND state and increments each cycle spent there.
  - Reaching TIMEOUT_CYCLES sets TIMEOUT=1. TIMEOUT is sticky until AXI_ARESET.
  - The transaction keeps waiting; the protocol is never violated.
- Undefined: no counter logic; TIMEOUT tied to 0.

## Structure
- Package axil_pkg holds:
  - Response localparams OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - The state enum.
  - Default width constants.
- One sub-module, axil_timeout_counter: parameter LIMIT; inputs clear and enable; sticky output expired. It is instantiated only under the macro.

## Test plan
- Write 0x0000_0010 ← 0xDEAD_BEEF; slave with AW/W/B ready zero-wait → AWVALID and WVALID at cycle 1; RSP_VALID at cycle 3 with RSP_RESP=0 and RSP_DATA=0.
- Read 0x0000_000C; slave returns 0x0727_07E6 → RSP_DATA=0x0727_07E6, RSP_RESP=0, RSP_VALID at cycle 3.
- Write with WREADY delayed 5 cycles after AWREADY → AWVALID drops after its handshake; WVALID is held stable until the handshake; exactly one B is accepted.
- Read returning RRESP=2 while RSP_READY is held low for 4 cycles → RSP_RESP=2 held stable; CMD_READY stays 0 until release.
- Reset asserted at cycle 2 of a pending write → next edge gives all VALIDs 0, CMD_READY=1, RSP_VALID=0.
- With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY → TIMEOUT=1 after 16 cycles in RD_ADDR and ARVALID stays 1; a later ARREADY completes the read normally.

Source files
------------

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared constants, state encoding and helpers for the AXI4-Lite master engine
package axil_pkg;

  localparam int unsigned AXIL_DATA_WIDTH_DEF = 32;
  localparam int unsigned AXIL_ADDR_WIDTH_DEF = 32;
  localparam int unsigned AXIL_TIMEOUT_DEF    = 1024;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WR_ADDR_DATA = 3'd1,
    ST_WR_RESP      = 3'd2,
    ST_RD_ADDR      = 3'd3,
    ST_RD_DATA      = 3'd4,
    ST_RESPOND      = 3'd5
  } axil_state_e;

  // States in which the engine is waiting on the slave and the watchdog runs.
  function automatic logic is_wait_state(input axil_state_e s);
    return (s != ST_IDLE) && (s != ST_RESPOND);
  endfunction

endpackage

// File: rtl/axil_timeout_counter.sv
// rtl/axil_timeout_counter.sv - saturating cycle counter with a sticky expired flag
module axil_timeout_counter #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          expired_q, expired_d;

  // The count saturates at LAST; the flag is set on the LIMIT-th enabled cycle.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (enable_i && (cnt_q == LAST)) begin
      expired_d = 1'b1;
    end
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/axil_master_engine.sv
// rtl/axil_master_engine.sv - single-outstanding AXI4-Lite master driven by a command/response handshake
// Optional slave-stall watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axil_master_engine
  import axil_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH = AXIL_DATA_WIDTH_DEF,
  parameter int unsigned AXI_ADDR_WIDTH = AXIL_ADDR_WIDTH_DEF,
  parameter int unsigned TIMEOUT_CYCLES = AXIL_TIMEOUT_DEF
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESET,
  input  logic                          CMD_VALID,
  output logic                          CMD_READY,
  input  logic                          CMD_WRITE,
  input  logic [AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
  input  logic [AXI_DATA_WIDTH-1:0]     CMD_WDATA,
  output logic                          RSP_VALID,
  input  logic                          RSP_READY,
  output logic [AXI_DATA_WIDTH-1:0]     RSP_DATA,
  output logic [1:0]                    RSP_RESP,
  output logic                          TIMEOUT,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic [AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  output logic [2:0]                    M_AXI_ARPROT,
  input  logic [AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  axil_state_e               state_q, state_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [AXI_DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]                rsp_resp_q, rsp_resp_d;

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          addr_d  = CMD_ADDR;
          wdata_d = CMD_WDATA;
          if (CMD_WRITE) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      // AW and W retire independently; leave once neither is still pending.
      ST_WR_ADDR_DATA: begin
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d = M_AXI_BRESP;
          rsp_data_d = '0;
          state_d    = ST_RESPOND;
        end
      end
      ST_RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_resp_d = M_AXI_RRESP;
          rsp_data_d = M_AXI_RDATA;
          state_d    = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (RSP_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      state_q    <= ST_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_resp_q <= OKAY;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
    end
  end

  assign CMD_READY     = (state_q == ST_IDLE);
  assign RSP_VALID     = (state_q == ST_RESPOND);
  assign RSP_DATA      = rsp_data_q;
  assign RSP_RESP      = rsp_resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == ST_WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == ST_RD_DATA);

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic to_clear;
  logic to_enable;

  // Restart the count on every entry into a slave-wait state.
  assign to_clear  = is_wait_state(state_d) && (state_d != state_q);
  assign to_enable = is_wait_state(state_q);

  axil_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (AXI_ACLK),
    .rst_i     (AXI_ARESET),
    .clear_i   (to_clear),
    .enable_i  (to_enable),
    .expired_o (TIMEOUT)
  );
`else
  // Watchdog compiled out; the limit parameter stays so both builds share one interface.
  localparam bit TIMEOUT_LIMIT_SET = (TIMEOUT_CYCLES != 0);
  assign TIMEOUT = 1'b0 & TIMEOUT_LIMIT_SET;
`endif

endmodule

// File: tb/tb_axil_master_engine.sv
// tb/tb_axil_master_engine.sv - scoreboard bench for axil_master_engine with a reactive AXI4-Lite slave
module tb_axil_master_engine;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 16;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic          CMD_VALID, CMD_READY, CMD_WRITE;
  logic [AW-1:0] CMD_ADDR;
  logic [DW-1:0] CMD_WDATA;
  logic          RSP_VALID, RSP_READY;
  logic [DW-1:0] RSP_DATA;
  logic [1:0]    RSP_RESP;
  logic          TIMEOUT;
  logic [AW-1:0] AWADDR, ARADDR;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [DW/8-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;

  always #5 clk = ~clk;

  axil_master_engine #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .AXI_ACLK (clk), .AXI_ARESET (rst),
    .CMD_VALID (CMD_VALID), .CMD_READY (CMD_READY), .CMD_WRITE (CMD_WRITE),
    .CMD_ADDR (CMD_ADDR), .CMD_WDATA (CMD_WDATA),
    .RSP_VALID (RSP_VALID), .RSP_READY (RSP_READY), .RSP_DATA (RSP_DATA),
    .RSP_RESP (RSP_RESP), .TIMEOUT (TIMEOUT),
    .M_AXI_AWADDR (AWADDR), .M_AXI_AWVALID (AWVALID), .M_AXI_AWREADY (AWREADY), .M_AXI_AWPROT (AWPROT),
    .M_AXI_WDATA (WDATA), .M_AXI_WSTRB (WSTRB), .M_AXI_WVALID (WVALID), .M_AXI_WREADY (WREADY),
    .M_AXI_BRESP (BRESP), .M_AXI_BVALID (BVALID), .M_AXI_BREADY (BREADY),
    .M_AXI_ARADDR (ARADDR), .M_AXI_ARVALID (ARVALID), .M_AXI_ARREADY (ARREADY), .M_AXI_ARPROT (ARPROT),
    .M_AXI_RDATA (RDATA), .M_AXI_RRESP (RRESP), .M_AXI_RVALID (RVALID), .M_AXI_RREADY (RREADY)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;
  exp_t sb_q[$];

  // Slave configuration (wait of -1 means the ready never rises).
  int          cfg_aw_wait, cfg_w_wait, cfg_ar_wait, cfg_b_wait, cfg_r_wait;
  logic [1:0]  cfg_bresp, cfg_rresp;
  logic [DW-1:0] cfg_rdata;

  // Slave-side observations.
  int aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, ar_hs_n = 0, r_hs_n = 0;
  logic [AW-1:0] seen_awaddr, seen_araddr;
  logic [DW-1:0] seen_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reactive slave: decides its outputs at each falling edge from the DUT's registered outputs.
  initial begin : slave
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic aw_got, w_got, ar_got, p_aw, p_w, p_b, p_ar, p_r;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RRESP = 0; RDATA = '0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_got = 0; w_got = 0; ar_got = 0;
    p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; ar_got = 0;
        p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
      end else begin
        if (p_aw) begin aw_hs_n++; aw_got = 1; end
        if (p_w)  begin w_hs_n++;  w_got = 1;  end
        if (p_b)  begin b_hs_n++;  BVALID = 0; end
        if (p_ar) begin ar_hs_n++; ar_got = 1; end
        if (p_r)  begin r_hs_n++;  RVALID = 0; end
        if (AWVALID) begin AWREADY = (cfg_aw_wait >= 0) && (aw_cnt >= cfg_aw_wait); aw_cnt++; end
        else begin AWREADY = 0; aw_cnt = 0; end
        if (WVALID) begin WREADY = (cfg_w_wait >= 0) && (w_cnt >= cfg_w_wait); w_cnt++; end
        else begin WREADY = 0; w_cnt = 0; end
        if (ARVALID) begin ARREADY = (cfg_ar_wait >= 0) && (ar_cnt >= cfg_ar_wait); ar_cnt++; end
        else begin ARREADY = 0; ar_cnt = 0; end
        if (aw_got && w_got && !BVALID) begin
          if (b_cnt >= cfg_b_wait) begin
            BVALID = 1; BRESP = cfg_bresp; aw_got = 0; w_got = 0; b_cnt = 0;
          end else b_cnt++;
        end
        if (ar_got && !RVALID) begin
          if (r_cnt >= cfg_r_wait) begin
            RVALID = 1; RRESP = cfg_rresp; RDATA = cfg_rdata; ar_got = 0; r_cnt = 0;
          end else r_cnt++;
        end
        p_aw = AWVALID && AWREADY;
        p_w  = WVALID && WREADY;
        p_b  = BVALID && BREADY;
        p_ar = ARVALID && ARREADY;
        p_r  = RVALID && RREADY;
        if (p_aw) seen_awaddr = AWADDR;
        if (p_w)  seen_wdata  = WDATA;
        if (p_ar) seen_araddr = ARADDR;
      end
    end
  end

  task automatic cfg_default();
    cfg_aw_wait = 0; cfg_w_wait = 0; cfg_ar_wait = 0; cfg_b_wait = 0; cfg_r_wait = 0;
    cfg_bresp = 2'd0; cfg_rresp = 2'd0; cfg_rdata = '0;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1.
  task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [DW-1:0] exp_data, input logic [1:0] exp_resp);
    int n;
    exp_t e;
    n = 0;
    CMD_VALID = 1; CMD_WRITE = wr; CMD_ADDR = addr; CMD_WDATA = data;
    while (!CMD_READY && n < BUDGET) begin @(negedge clk); n++; end
    check("cmd_accept_in_time", 64'(n >= BUDGET), 64'(0));
    accept_cyc = cyc;
    e.data = exp_data;
    e.resp = exp_resp;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '1; CMD_WDATA = '1;
  endtask

  task automatic collect(input int hold, input int exp_lat);
    int n;
    exp_t e;
    n = 0;
    while (!RSP_VALID && n < BUDGET) begin @(negedge clk); n++; end
    check("rsp_in_time", 64'(n >= BUDGET), 64'(0));
    if (exp_lat >= 0) check("rsp_latency", 64'(cyc - accept_cyc), 64'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", 64'(RSP_VALID), 64'(1));
      check("hold_cmd_ready", 64'(CMD_READY), 64'(0));
      if (sb_q.size() > 0) check("hold_rsp_resp", 64'(RSP_RESP), 64'(sb_q[0].resp));
      @(negedge clk);
    end
    RSP_READY = 1;
    check("sb_nonempty", 64'(sb_q.size() == 0), 64'(0));
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("rsp_data", 64'(RSP_DATA), 64'(e.data));
      check("rsp_resp", 64'(RSP_RESP), 64'(e.resp));
    end
    @(posedge clk);
    @(negedge clk);
    RSP_READY = 0;
    check("cmd_ready_after_rsp", 64'(CMD_READY), 64'(1));
    check("rsp_valid_after_rsp", 64'(RSP_VALID), 64'(0));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin : main
    int b0, aw0, w0;
    logic wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [1:0] r;
    rst = 1; CMD_VALID = 0; CMD_WRITE = 0; CMD_ADDR = '0; CMD_WDATA = '0; RSP_READY = 0;
    cfg_default();
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 64'(CMD_READY), 64'(1));
    check("rst_rsp_valid", 64'(RSP_VALID), 64'(0));
    check("rst_rsp_data", 64'(RSP_DATA), 64'(0));
    check("rst_rsp_resp", 64'(RSP_RESP), 64'(0));
    check("rst_timeout", 64'(TIMEOUT), 64'(0));
    check("rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'(0));
    check("rst_awaddr", 64'(AWADDR), 64'(0));
    check("rst_wdata", 64'(WDATA), 64'(0));
    rst = 0;
    @(negedge clk);

    // Zero-wait write.
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    issue(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 2'd0);
    check("wr_awvalid_c1", 64'(AWVALID), 64'(1));
    check("wr_wvalid_c1", 64'(WVALID), 64'(1));
    check("wr_arvalid_c1", 64'(ARVALID), 64'(0));
    check("wr_awaddr_c1", 64'(AWADDR), 64'h10);
    check("wr_wdata_c1", 64'(WDATA), 64'hDEAD_BEEF);
    check("wr_wstrb", 64'(WSTRB), 64'hF);
    check("wr_prot", 64'({AWPROT, ARPROT}), 64'(0));
    collect(0, 3);
    check("wr_one_aw", 64'(aw_hs_n - aw0), 64'(1));
    check("wr_one_w", 64'(w_hs_n - w0), 64'(1));
    check("wr_one_b", 64'(b_hs_n - b0), 64'(1));

    // Zero-wait read.
    cfg_rdata = 32'h0727_07E6;
    issue(1'b0, 32'h0000_000C, 32'h0, 32'h0727_07E6, 2'd0);
    check("rd_arvalid_c1", 64'(ARVALID), 64'(1));
    check("rd_awvalid_c1", 64'(AWVALID), 64'(0));
    check("rd_araddr_c1", 64'(ARADDR), 64'hC);
    collect(0, 3);

    // WREADY five cycles after AWREADY.
    cfg_default();
    cfg_w_wait = 5;
    aw0 = aw_hs_n; w0 = w_hs_n; b0 = b_hs_n;
    issue(1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0, 2'd0);
    check("slow_w_awvalid_c1", 64'(AWVALID), 64'(1));
    for (int c = 2; c <= 6; c++) begin
      @(negedge clk);
      check("slow_w_awvalid_drop", 64'(AWVALID), 64'(0));
      check("slow_w_wvalid_held", 64'(WVALID), 64'(1));
      check("slow_w_wdata_stable", 64'(WDATA), 64'h1234_5678);
    end
    @(negedge clk);
    check("slow_w_wvalid_done", 64'(WVALID), 64'(0));
    collect(0, 8);
    repeat (3) @(negedge clk);
    check("slow_w_one_aw", 64'(aw_hs_n - aw0), 64'(1));
    check("slow_w_one_w", 64'(w_hs_n - w0), 64'(1));
    check("slow_w_one_b", 64'(b_hs_n - b0), 64'(1));

    // SLVERR read with consumer back-pressure.
    cfg_default();
    cfg_rresp = 2'd2; cfg_rdata = 32'hA5A5_0001;
    issue(1'b0, 32'h0000_0040, 32'h0, 32'hA5A5_0001, 2'd2);
    collect(4, 3);

    // DECERR write with a slow B.
    cfg_default();
    cfg_bresp = 2'd3; cfg_b_wait = 2;
    issue(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 32'h0, 2'd3);
    collect(0, 5);

    // Randomised traffic.
    for (int i = 0; i < 8; i++) begin
      cfg_aw_wait = $urandom_range(0, 3); cfg_w_wait = $urandom_range(0, 3);
      cfg_ar_wait = $urandom_range(0, 3); cfg_b_wait = $urandom_range(0, 3);
      cfg_r_wait = $urandom_range(0, 3);
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      cfg_rdata = $urandom;
      wr = 1'($urandom_range(0, 1));
      a = {$urandom_range(0, 1023), 2'b00};
      d = $urandom;
      r = wr ? cfg_bresp : cfg_rresp;
      issue(wr, a, d, wr ? 32'h0 : cfg_rdata, r);
      collect($urandom_range(0, 2), -1);
      if (wr) begin
        check("rnd_awaddr", 64'(seen_awaddr), 64'(a));
        check("rnd_wdata", 64'(seen_wdata), 64'(d));
      end else begin
        check("rnd_araddr", 64'(seen_araddr), 64'(a));
      end
    end

    // Reset in the middle of a stalled write.
    cfg_default();
    cfg_aw_wait = -1; cfg_w_wait = -1;
    issue(1'b1, 32'h0000_0080, 32'h5555_AAAA, 32'h0, 2'd0);
    check("mid_rst_awvalid_pre", 64'(AWVALID), 64'(1));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    check("mid_rst_valids", 64'({AWVALID, WVALID, ARVALID, BREADY, RREADY}), 64'(0));
    check("mid_rst_cmd_ready", 64'(CMD_READY), 64'(1));
    check("mid_rst_rsp_valid", 64'(RSP_VALID), 64'(0));
    sb_q.delete();
    @(negedge clk);
    rst = 0;
    cfg_default();
    @(negedge clk);
    cfg_rdata = 32'h0BAD_CAFE;
    issue(1'b0, 32'h0000_0084, 32'h0, 32'h0BAD_CAFE, 2'd0);
    collect(0, 3);

`ifdef AXIL_MASTER_TIMEOUT_EN
    // Slave never raises ARREADY until released.
    cfg_default();
    cfg_ar_wait = -1; cfg_rdata = 32'h7777_0016;
    issue(1'b0, 32'h0000_0100, 32'h0, 32'h7777_0016, 2'd0);
    repeat (15) @(negedge clk);
    check("to_not_yet", 64'(TIMEOUT), 64'(0));
    check("to_arvalid_c16", 64'(ARVALID), 64'(1));
    @(negedge clk);
    check("to_set", 64'(TIMEOUT), 64'(1));
    check("to_arvalid_c17", 64'(ARVALID), 64'(1));
    cfg_ar_wait = 0;
    collect(0, -1);
    check("to_sticky", 64'(TIMEOUT), 64'(1));
`else
    check("no_timeout_build", 64'(TIMEOUT), 64'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
